// File: rtl/parking_slot_allocator.sv
// parking_slot_allocator: occupancy bitmap with lowest-free allocation, exit release and entry-gate FSM
module parking_slot_allocator #(
   parameter int unsigned GATE_CYCLES = 16,
   parameter logic [7:0]  INIT_OCC    = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       entry_req,
   input  logic       car_passed,
   input  logic       exit_req,
   input  logic [2:0] exit_slot,
   output logic [7:0] new_capacity,
   output logic       full,
   output logic [2:0] assigned_slot,
   output logic       entry_ack,
   output logic       entry_reject,
   output logic       exit_ack,
   output logic       exit_err,
   output logic       gate_open
);
   typedef enum logic [1:0] {IDLE, GATE, RELEASE} state_t;
   state_t     state, state_nx;
   logic [7:0] timer, timer_nx, set_mask, clr_mask;
   logic [2:0] free_idx;
   logic       alloc, reject, exit_hit;
   assign full = new_capacity == 8'hFF;
   // descending scan so the last hit is the lowest free index
   always_comb begin
      free_idx = 3'd0;
      for (int i = 7; i >= 0; i--) if (!new_capacity[i]) free_idx = 3'(i);
   end
   always_comb begin
      state_nx = state;
      timer_nx = timer;
      alloc    = 1'b0;
      reject   = 1'b0;
      case (state)
         IDLE: if (entry_req) begin
            alloc    = !full;
            reject   = full;
            state_nx = full ? RELEASE : GATE;
            timer_nx = full ? timer : 8'(GATE_CYCLES);
         end
         GATE: begin
            timer_nx = timer - 8'd1;
            if (car_passed || timer == 8'd1) state_nx = RELEASE;
         end
         RELEASE: if (!entry_req) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // both masks come from the pre-edge bitmap, so set and clear never touch the same bit
   assign exit_hit = exit_req && new_capacity[exit_slot];
   assign set_mask = alloc ? 8'd1 << free_idx : 8'd0;
   assign clr_mask = exit_hit ? 8'd1 << exit_slot : 8'd0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         timer         <= 8'd0;
         new_capacity  <= INIT_OCC;
         assigned_slot <= 3'd0;
         entry_ack     <= 1'b0;
         entry_reject  <= 1'b0;
         exit_ack      <= 1'b0;
         exit_err      <= 1'b0;
         gate_open     <= 1'b0;
      end else begin
         state         <= state_nx;
         timer         <= timer_nx;
         new_capacity  <= (new_capacity & ~clr_mask) | set_mask;
         assigned_slot <= alloc ? free_idx : assigned_slot;
         entry_ack     <= alloc;
         entry_reject  <= reject;
         exit_ack      <= exit_hit;
         exit_err      <= exit_req && !exit_hit;
         gate_open     <= state == GATE;
      end
   end
endmodule

// File: tb/tb_parking_slot_allocator.sv
// tb_parking_slot_allocator: directed test-plan steps plus random traffic against a reference model
module tb_parking_slot_allocator;
   localparam int GC = 4;
   logic       clk = 1'b0, rst_n = 1'b0, entry_req = 1'b0, car_passed = 1'b0, exit_req = 1'b0;
   logic [2:0] exit_slot = 3'd0;
   logic [7:0] new_capacity;
   logic [2:0] assigned_slot;
   logic       full, entry_ack, entry_reject, exit_ack, exit_err, gate_open;
   int         checks = 0, errors = 0, gate_hi;
   bit [7:0]   occ;
   int         slot_m, elapsed;
   bit         in_gate, hold, e_ack, e_rej, x_ack, x_err, e_gate;

   always #5 clk = ~clk;

   parking_slot_allocator #(.GATE_CYCLES(GC), .INIT_OCC(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .car_passed(car_passed),
      .exit_req(exit_req), .exit_slot(exit_slot), .new_capacity(new_capacity), .full(full),
      .assigned_slot(assigned_slot), .entry_ack(entry_ack), .entry_reject(entry_reject),
      .exit_ack(exit_ack), .exit_err(exit_err), .gate_open(gate_open)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_cap"}, new_capacity, occ);
      chk({tag, "_full"}, {7'd0, full}, {7'd0, occ == 8'hFF});
      chk({tag, "_slot"}, {5'd0, assigned_slot}, 8'(slot_m));
      chk({tag, "_eack"}, {7'd0, entry_ack}, {7'd0, e_ack});
      chk({tag, "_erej"}, {7'd0, entry_reject}, {7'd0, e_rej});
      chk({tag, "_xack"}, {7'd0, exit_ack}, {7'd0, x_ack});
      chk({tag, "_xerr"}, {7'd0, exit_err}, {7'd0, x_err});
      chk({tag, "_gate"}, {7'd0, gate_open}, {7'd0, e_gate});
   endtask

   task automatic model_reset();
      occ = 8'h00; slot_m = 0; in_gate = 0; hold = 0; elapsed = 0;
      e_ack = 0; e_rej = 0; x_ack = 0; x_err = 0; e_gate = 0;
   endtask

   // one clock: drive inputs, advance the model from the pre-edge picture, then compare
   task automatic step(input string tag, input bit er, input bit cp, input bit xr, input logic [2:0] xs);
      bit [7:0] pre;
      int lo;
      entry_req = er; car_passed = cp; exit_req = xr; exit_slot = xs;
      pre = occ; lo = -1;
      e_gate = in_gate; e_ack = 0; e_rej = 0; x_ack = 0; x_err = 0;
      if (!in_gate && !hold) begin
         if (er) begin
            for (int i = 0; i < 8; i++) if (!pre[i] && lo < 0) lo = i;
            if (lo < 0) begin e_rej = 1; hold = 1; end
            else begin e_ack = 1; slot_m = lo; in_gate = 1; elapsed = 0; end
         end
      end else if (in_gate) begin
         elapsed++;
         if (cp || elapsed == GC) begin in_gate = 0; hold = 1; end
      end else if (!er) hold = 0;
      if (xr) begin
         if (pre[xs]) begin x_ack = 1; occ[xs] = 0; end
         else x_err = 1;
      end
      if (lo >= 0) occ[lo] = 1;
      @(posedge clk); #1;
      check_all(tag);
   endtask

   task automatic park_car(input string tag);
      step(tag, 1, 0, 0, 3'd0);
      step(tag, 0, 1, 0, 3'd0);
      step(tag, 0, 0, 0, 3'd0);
   endtask

   initial begin
      #1 model_reset();
      check_all("reset");
      #7 rst_n = 1'b1;
      step("tp1_ack", 1, 0, 0, 3'd0);
      chk("tp1_cap", new_capacity, 8'h01);
      chk("tp1_ack", {7'd0, entry_ack}, 8'd1);
      step("tp1_gate", 1, 0, 0, 3'd0);
      chk("tp1_gate", {7'd0, gate_open}, 8'd1);
      step("tp1_pass", 0, 1, 0, 3'd0);
      step("tp1_idle", 0, 0, 0, 3'd0);
      for (int n = 0; n < 7; n++) park_car("fill");
      chk("fill_cap", new_capacity, 8'hFF);
      step("rej", 1, 0, 0, 3'd0);
      chk("rej_pulse", {7'd0, entry_reject}, 8'd1);
      chk("rej_full", {7'd0, full}, 8'd1);
      step("rej_hold", 1, 0, 0, 3'd0);
      chk("rej_single", {7'd0, entry_reject}, 8'd0);
      step("rej_idle", 0, 0, 0, 3'd0);
      step("free3", 0, 0, 1, 3'd3);
      step("free6", 0, 0, 1, 3'd6);
      chk("b7_cap", new_capacity, 8'hB7);
      step("tp2_alloc", 1, 0, 0, 3'd0);
      chk("tp2_slot", {5'd0, assigned_slot}, 8'd3);
      chk("tp2_cap", new_capacity, 8'hBF);
      step("tp2_pass", 1, 1, 0, 3'd0);
      for (int n = 0; n < 3; n++) step("tp2_hold", 1, 0, 0, 3'd0);
      chk("tp2_noalloc", new_capacity, 8'hBF);
      step("tp2_idle", 0, 0, 0, 3'd0);
      step("to0f", 0, 0, 1, 3'd7);
      step("to0f", 0, 0, 1, 3'd5);
      step("to0f", 0, 0, 1, 3'd4);
      step("tp4_ack", 0, 0, 1, 3'd2);
      chk("tp4_cap", new_capacity, 8'h0B);
      step("tp4_err", 0, 0, 1, 3'd6);
      chk("tp4_err", {7'd0, exit_err}, 8'd1);
      for (int n = 0; n < 4; n++) park_car("to7f");
      chk("7f_cap", new_capacity, 8'h7F);
      step("tp5", 1, 0, 1, 3'd0);
      chk("tp5_cap", new_capacity, 8'hFE);
      gate_hi = 0;
      for (int n = 0; n < 6; n++) begin
         step("tmo", 0, 0, 0, 3'd0);
         if (gate_open === 1'b1) gate_hi++;
      end
      chk("tmo_cycles", 8'(gate_hi), 8'd4);
      step("same_slot", 1, 0, 1, 3'd0);
      chk("same_slot_err", {7'd0, exit_err}, 8'd1);
      step("mid_gate", 0, 0, 0, 3'd0);
      chk("mid_gate_open", {7'd0, gate_open}, 8'd1);
      rst_n = 1'b0;
      #1 model_reset();
      check_all("async_rst");
      chk("async_rst_cap", new_capacity, 8'h00);
      #2 rst_n = 1'b1;
      for (int n = 0; n < 400; n++)
         step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/parking_slot_allocator.md
Name: parking_slot_allocator

Overview:
- Sequential stage directly upstream of the occupancy ones-counter.
- Maintains the 8-bit occupancy bitmap `new_capacity` (bit i = 1 means space i is taken) from entry and exit requests.
- Allocates the lowest free space to an arriving car and releases spaces on exit.
- Drives the entry gate through a small state machine; `new_capacity` feeds the counter that produces the `parked` count.

Parameters:
- GATE_CYCLES, 16, maximum number of cycles `gate_open` stays high per admitted car (legal range 1..255).
- INIT_OCC, 8'h00, occupancy bitmap loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- entry_req  input  1  level request from the entry sensor; held high until the car is served or rejected.
- car_passed  input  1  gate sensor pulse; the car has cleared the gate.
- exit_req  input  1  single-cycle pulse; a car leaves space `exit_slot`.
- exit_slot  input  3  index of the space being vacated; valid when `exit_req`=1.
- new_capacity  output  8  registered occupancy bitmap, fed to the ones-counter.
- full  output  1  combinational, equal to (`new_capacity`==8'hFF).
- assigned_slot  output  3  registered index of the last allocated space.
- entry_ack  output  1  registered single-cycle pulse; space allocated.
- entry_reject  output  1  registered single-cycle pulse; lot full.
- exit_ack  output  1  registered single-cycle pulse; space released.
- exit_err  output  1  registered single-cycle pulse; exit for an already-free space.
- gate_open  output  1  registered; high while the FSM is in GATE.

Behaviour:
- Reset (async, `rst_n`=0):
  - `new_capacity`=INIT_OCC, `assigned_slot`=0.
  - All pulses=0, `gate_open`=0, state=IDLE, timer=0.
  - Reset asserted mid-GATE closes the gate immediately; any allocation already committed is overwritten by INIT_OCC.
- FSM states: IDLE, GATE, RELEASE.
- IDLE:
  - On an edge with `entry_req`=1 and `full`=0:
    - set the bit of the lowest-index free space;
    - `assigned_slot` takes that index;
    - `entry_ack`=1 for one cycle;
    - timer loads GATE_CYCLES;
    - next state GATE.
  - On an edge with `entry_req`=1 and `full`=1:
    - `entry_reject`=1 for one cycle;
    - bitmap unchanged;
    - next state RELEASE.
  - `entry_req`=0: stay in IDLE.
- GATE:
  - `gate_open`=1 from the cycle after entering GATE.
  - The timer decrements each cycle.
  - Leave to RELEASE on the first edge where `car_passed`=1 or timer==1.
  - The gate is therefore high for at most GATE_CYCLES cycles.
  - Timeout does not undo the allocation.
- RELEASE:
  - `gate_open`=0.
  - Wait until `entry_req`=0, then go to IDLE. This takes a minimum of one cycle in RELEASE.
  - A held request therefore never allocates twice.
- Latency: `entry_req` sampled at edge k; `entry_ack`, the updated `new_capacity` and `assigned_slot` are all visible after edge k.
- Exit path runs independently of the FSM, in any state, one request per cycle:
  - `exit_req`=1 with bit[`exit_slot`]=1: clear the bit; `exit_ack`=1 for one cycle.
  - `exit_req`=1 with bit[`exit_slot`]=0: bitmap unchanged; `exit_err`=1 for one cycle.
- Simultaneous entry allocation and exit on the same edge:
  - The allocation search uses the pre-edge bitmap, so the freed space is not reused that cycle.
  - Both the set and the clear apply.
  - With a full lot, the entry is rejected even if an exit occurs on the same edge.
- Exit for the space being allocated on the same edge: that space was free pre-edge, so the exit gives `exit_err`; the allocation still sets the bit.
- `car_passed` outside GATE is ignored.
- At most one bit is set per edge and at most one bit is cleared per edge, so `new_capacity` population changes by at most 1 per cycle.

Test Plan:
- Reset with INIT_OCC=8'h00, then `entry_req`=1: `entry_ack` pulses after the next edge, `assigned_slot`=0, `new_capacity`=8'h01, `gate_open`=1 the following cycle.
- Bitmap 8'b1011_0111, `entry_req`=1: `assigned_slot`=3, `new_capacity`=8'hBF. Then `car_passed` pulse: `gate_open` drops and the FSM waits in RELEASE while `entry_req` stays high, with no second allocation.
- Bitmap 8'hFF, `entry_req`=1: `entry_reject` single pulse, `new_capacity` stays 8'hFF, `gate_open` stays 0, `full`=1.
- Bitmap 8'h0F:
  - `exit_req`=1 with `exit_slot`=2: `exit_ack`=1, `new_capacity`=8'h0B.
  - Then `exit_slot`=6: `exit_err`=1, `new_capacity` unchanged.
- Bitmap 8'h7F, `entry_req` and `exit_req` (`exit_slot`=0) on the same edge: `new_capacity`=8'hFE (space 7 allocated, space 0 freed), `entry_ack`=1 and `exit_ack`=1.
- GATE_CYCLES=4 with no `car_passed`: `gate_open` high exactly 4 cycles, then RELEASE. Assert `rst_n`=0 mid-GATE in a second run: `gate_open`=0 and `new_capacity`=INIT_OCC immediately, without waiting for a clock edge.
